// File: rtl/mem_mod_mp_pkg.sv
// rtl/mem_mod_mp_pkg.sv - shared limits, types and byte-merge helper for the multi-port word memory
package mem_mod_mp_pkg;

    localparam int NUM_PORTS_MAX = 4;
    localparam int LAT_MAX       = 4;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  be_t;

    typedef struct packed {
        logic  valid;
        logic  err;
        word_t data;
    } resp_t;

    function automatic word_t be_merge(input word_t old_w, input word_t new_w, input be_t be);
        word_t m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_mod_mp_if.sv
// rtl/mem_mod_mp_if.sv - per-port req/gnt/rvalid bus bundle between requesters and the memory
interface mem_mod_mp_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]       req_i;
    logic [NUM_PORTS-1:0]       gnt_o;
    logic [NUM_PORTS-1:0][31:0] addr_i;
    logic [NUM_PORTS-1:0]       we_i;
    logic [NUM_PORTS-1:0][3:0]  be_i;
    logic [NUM_PORTS-1:0][31:0] wdata_i;
    logic [NUM_PORTS-1:0]       rvalid_o;
    logic [NUM_PORTS-1:0][31:0] rdata_o;
    logic [NUM_PORTS-1:0]       err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/mem_mod_mp_rr_arbiter.sv
// rtl/mem_mod_mp_rr_arbiter.sv - round-robin arbiter: combinational one-hot grant, pointer moves past each winner
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next;
    logic [PW-1:0] w_idx;
    logic          w_any;
    int            w_idx_i;

    // Search wraps from r_ptr so the last winner has lowest priority next time.
    always_comb begin
        o_gnt   = '0;
        w_next  = r_ptr;
        w_any   = 1'b0;
        w_idx   = '0;
        w_idx_i = 0;
        for (int i = 0; i < N; i++) begin
            w_idx_i = int'(r_ptr) + i;
            if (w_idx_i >= N) w_idx_i = w_idx_i - N;
            w_idx = PW'(w_idx_i);
            if (!w_any && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_any        = 1'b1;
                w_next       = (w_idx_i == N - 1) ? '0 : PW'(w_idx_i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_ptr <= '0;
        else if (w_any) r_ptr <= w_next;
    end

endmodule

// File: rtl/mem_mod_mp.sv
// rtl/mem_mod_mp.sv - multi-port word memory with round-robin access and per-port response pipeline
// Optional feature: MEM_MAILBOX_EN adds flag/result shadow registers and the done pulse.
module mem_mod_mp
    import mem_mod_mp_pkg::*;
#(
    parameter int          NUM_PORTS = 2,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1
`ifdef MEM_MAILBOX_EN
    ,
    parameter logic [31:0] FLAG_ADDR = 32'h0,
    parameter logic [31:0] RES_ADDR  = 32'h10
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_mod_mp_if.slave bus,
    output word_t       mem_flag_o,
    output word_t       mem_result_o,
    output logic        done_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LAT = (LATENCY < 1) ? 1 : ((LATENCY > LAT_MAX) ? LAT_MAX : LATENCY);

    logic [NUM_PORTS-1:0] w_gnt;
    logic                 w_acc;
    logic                 w_we;
    logic                 w_oor;
    logic                 w_wr;
    logic                 w_unused_addr;
    word_t                w_addr;
    word_t                w_wdata;
    word_t                w_rd;
    be_t                  w_be;
    logic [AW-1:0]        w_idx;

    word_t                r_mem  [DEPTH];
    resp_t                r_pipe [LAT][NUM_PORTS];

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (bus.req_i),
        .o_gnt (w_gnt)
    );

    assign bus.gnt_o = w_gnt;

    always_comb begin
        w_addr  = '0;
        w_we    = 1'b0;
        w_be    = '0;
        w_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt[p]) begin
                w_addr  = bus.addr_i[p];
                w_we    = bus.we_i[p];
                w_be    = bus.be_i[p];
                w_wdata = bus.wdata_i[p];
            end
        end
    end

    // DEPTH is a power of two, so any set bit above the index field means out of range.
    assign w_acc         = |w_gnt;
    assign w_idx         = w_addr[AW+1:2];
    assign w_oor         = |w_addr[31:AW+2];
    assign w_wr          = w_acc && w_we && !w_oor;
    assign w_rd          = (w_we || w_oor) ? '0 : r_mem[w_idx];
    assign w_unused_addr = ^w_addr[1:0];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_idx] <= be_merge(r_mem[w_idx], w_wdata, w_be);
    end

    // data/err only advance with a valid entry, so the outputs hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    r_pipe[s][p] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_pipe[0][p].valid <= w_gnt[p];
                if (w_gnt[p]) begin
                    r_pipe[0][p].err  <= w_oor;
                    r_pipe[0][p].data <= w_rd;
                end
                for (int s = 1; s < LAT; s++) begin
                    r_pipe[s][p].valid <= r_pipe[s-1][p].valid;
                    if (r_pipe[s-1][p].valid) begin
                        r_pipe[s][p].err  <= r_pipe[s-1][p].err;
                        r_pipe[s][p].data <= r_pipe[s-1][p].data;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.rvalid_o = '0;
        bus.err_o    = '0;
        bus.rdata_o  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.rvalid_o[p] = r_pipe[LAT-1][p].valid;
            bus.err_o[p]    = r_pipe[LAT-1][p].err;
            bus.rdata_o[p]  = r_pipe[LAT-1][p].data;
        end
    end

`ifdef MEM_MAILBOX_EN
    word_t r_flag;
    word_t r_res;
    logic  r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= '0;
            r_res  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_wr && (w_addr[31:2] == FLAG_ADDR[31:2])) begin
                r_flag <= be_merge(r_flag, w_wdata, w_be);
                r_done <= (w_wdata != '0);
            end
            if (w_wr && (w_addr[31:2] == RES_ADDR[31:2])) begin
                r_res <= be_merge(r_res, w_wdata, w_be);
            end
        end
    end

    assign mem_flag_o   = r_flag;
    assign mem_result_o = r_res;
    assign done_o       = r_done;
`else
    assign mem_flag_o   = '0;
    assign mem_result_o = '0;
    assign done_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_mod_mp.sv
// tb/tb_mem_mod_mp.sv - directed self-checking bench for mem_mod_mp (LATENCY 1 and 3 instances)
module tb_mem_mod_mp;
    import mem_mod_mp_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_mod_mp_if #(.NUM_PORTS(2)) b0 ();
    mem_mod_mp_if #(.NUM_PORTS(2)) b1 ();

    word_t flag0, res0, flag1, res1;
    logic  done0, done1;

    mem_mod_mp #(.NUM_PORTS(2), .DEPTH(1024), .LATENCY(1)) u0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (b0),
        .mem_flag_o   (flag0),
        .mem_result_o (res0),
        .done_o       (done0)
    );

    mem_mod_mp #(.NUM_PORTS(2), .DEPTH(64), .LATENCY(3)) u1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (b1),
        .mem_flag_o   (flag1),
        .mem_result_o (res1),
        .done_o       (done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Single access on u0 port p; starts and ends at a negedge, returns the response.
    task automatic acc0(input int p, input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
        b0.req_i      = '0;
        b0.req_i[p]   = 1'b1;
        b0.we_i[p]    = we;
        b0.addr_i[p]  = addr;
        b0.be_i[p]    = be;
        b0.wdata_i[p] = wd;
        #1;
        check("gnt0", 32'(b0.gnt_o), 32'(1 << p));
        @(negedge clk);
        b0.req_i = '0;
        check("rvalid0", 32'(b0.rvalid_o), 32'(1 << p));
        rd = b0.rdata_o[p];
        er = b0.err_o[p];
    endtask

    task automatic acc1(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
        b1.req_i      = 2'b01;
        b1.we_i[0]    = we;
        b1.addr_i[0]  = addr;
        b1.be_i[0]    = 4'hF;
        b1.wdata_i[0] = wd;
        #1;
        check("gnt1", 32'(b1.gnt_o), 32'd1);
        @(negedge clk);
        b1.req_i = '0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge clk);
            check("rvalid1_lat", 32'(b1.rvalid_o), (k == 3) ? 32'd1 : 32'd0);
        end
        rd = b1.rdata_o[0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          rv0;
        int          rv1;
        int          cnt [2];
        logic [1:0]  eg;

        b0.req_i = '0; b0.we_i = '0; b0.addr_i = '0; b0.be_i = '0; b0.wdata_i = '0;
        b1.req_i = '0; b1.we_i = '0; b1.addr_i = '0; b1.be_i = '0; b1.wdata_i = '0;
        rd = '0; er = 1'b0; eg = '0; rv0 = 0; rv1 = 0; cnt[0] = 0; cnt[1] = 0;

        repeat (2) @(negedge clk);
        check("rst_rvalid", 32'(b0.rvalid_o), 32'd0);
        check("rst_rdata",  b0.rdata_o[0], 32'd0);
        check("rst_err",    32'(b0.err_o), 32'd0);
        check("rst_done",   32'(done0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both ports contend for six cycles; fresh pointer means P0 wins first.
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                check("rr_rvalid", 32'(b0.rvalid_o), 32'(eg));
                rv0 += int'(b0.rvalid_o[0]);
                rv1 += int'(b0.rvalid_o[1]);
            end
            if (c < 6) begin
                for (int p = 0; p < 2; p++) begin
                    b0.req_i[p]   = 1'b1;
                    b0.we_i[p]    = 1'b1;
                    b0.be_i[p]    = 4'hF;
                    b0.addr_i[p]  = ((p == 0) ? 32'h200 : 32'h300) + 32'(4 * cnt[p]);
                    b0.wdata_i[p] = ((p == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'(cnt[p]);
                end
                #1;
                eg = (c % 2 == 0) ? 2'b01 : 2'b10;
                check("rr_gnt", 32'(b0.gnt_o), 32'(eg));
                for (int p = 0; p < 2; p++) if (b0.gnt_o[p]) cnt[p]++;
            end else begin
                b0.req_i = '0;
            end
            @(negedge clk);
        end
        check("rr_count_p0", 32'(rv0), 32'd3);
        check("rr_count_p1", 32'(rv1), 32'd3);
        acc0(1, 1'b0, 32'h304, 4'hF, 32'h0, rd, er);
        check("rr_data_p1", rd, 32'hB000_0001);
        acc0(0, 1'b0, 32'h208, 4'hF, 32'h0, rd, er);
        check("rr_data_p0", rd, 32'hA000_0002);

        acc0(0, 1'b1, 32'h40, 4'hF, 32'hCAFE_BABE, rd, er);
        check("wr_resp_rdata", rd, 32'h0);
        acc0(0, 1'b0, 32'h40, 4'hF, 32'h0, rd, er);
        check("rd_data", rd, 32'hCAFE_BABE);
        check("rd_err", 32'(er), 32'd0);
        @(negedge clk);
        check("hold_rvalid", 32'(b0.rvalid_o), 32'd0);
        check("hold_rdata", b0.rdata_o[0], 32'hCAFE_BABE);

        acc0(0, 1'b1, 32'h80, 4'hF,    32'hFFFF_FFFF, rd, er);
        acc0(0, 1'b1, 32'h80, 4'b0101, 32'h0000_0000, rd, er);
        acc0(0, 1'b0, 32'h80, 4'hF,    32'h0, rd, er);
        check("be_merge", rd, 32'hFF00_FF00);

        acc0(0, 1'b1, 32'h0,   4'hF, 32'h1234_5678, rd, er);
        acc0(0, 1'b1, 32'hFFC, 4'hF, 32'h5A5A_5A5A, rd, er);
        acc0(0, 1'b0, 32'hFFC, 4'hF, 32'h0, rd, er);
        check("last_word", rd, 32'h5A5A_5A5A);
        check("last_word_err", 32'(er), 32'd0);
        acc0(0, 1'b0, 32'h1000, 4'hF, 32'h0, rd, er);
        check("oor_rd_data", rd, 32'h0);
        check("oor_rd_err", 32'(er), 32'd1);
        acc0(0, 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, rd, er);
        check("oor_wr_err", 32'(er), 32'd1);
        acc0(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, er);
        check("oor_word0", rd, 32'h1234_5678);
        check("oor_word0_err", 32'(er), 32'd0);

`ifdef MEM_MAILBOX_EN
        acc0(0, 1'b1, 32'h10, 4'hF, 32'h0000_002A, rd, er);
        check("mb_result", res0, 32'h0000_002A);
        acc0(0, 1'b1, 32'h0, 4'hF, 32'h0000_0001, rd, er);
        check("mb_done", 32'(done0), 32'd1);
        check("mb_flag", flag0, 32'h0000_0001);
        @(negedge clk);
        check("mb_done_pulse", 32'(done0), 32'd0);
`else
        check("mb_off_flag",   flag0, 32'h0);
        check("mb_off_result", res0, 32'h0);
        check("mb_off_done",   32'(done0), 32'd0);
`endif

        for (int c = 0; c < 4; c++) acc1(1'b1, 32'(4 * c), 32'h1111_0000 + 32'(c), rd);
        @(negedge clk);
        // Four back-to-back reads: responses expected on cycles 3..6.
        for (int c = 0; c < 9; c++) begin
            check("b2b_rvalid", 32'(b1.rvalid_o[0]), (c >= 3 && c <= 6) ? 32'd1 : 32'd0);
            if (c >= 3 && c <= 6) check("b2b_rdata", b1.rdata_o[0], 32'h1111_0000 + 32'(c - 3));
            if (c < 4) begin
                b1.req_i     = 2'b01;
                b1.we_i[0]   = 1'b0;
                b1.addr_i[0] = 32'(4 * c);
                #1;
                check("b2b_gnt", 32'(b1.gnt_o), 32'd1);
            end else begin
                b1.req_i = '0;
            end
            @(negedge clk);
        end

        b1.req_i     = 2'b01;
        b1.we_i[0]   = 1'b0;
        b1.addr_i[0] = 32'h8;
        @(negedge clk);
        b1.req_i = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rdata", b1.rdata_o[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("rst_mid_rvalid", 32'(b1.rvalid_o), 32'd0);
            @(negedge clk);
        end
        acc1(1'b0, 32'h8, 32'h0, rd);
        check("rst_keep_mem", rd, 32'h1111_0002);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
